// File: rtl/accel_pkg.sv
// Shared sizing defaults for the inter-layer buffers of the accelerator datapath.
package accel_pkg;
    localparam int LANE_W     = 16;
    localparam int PE_NUM     = 8;
    localparam int DEF_ADDR_W = 8;

    function automatic int word_width(input int lane_w, input int lanes);
        return lane_w * lanes;
    endfunction
endpackage

// File: rtl/sdp_bram.sv
// Simple dual-port RAM: one write port, one read port with a registered,
// enable-held output. Contents are never reset so the array maps onto block RAM.
module sdp_bram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/layer_pingpong_buffer.sv
// Two-bank ping-pong buffer between accelerator layers: the producer fills one
// bank while the consumer drains the other; ownership moves via commit/release.
module layer_pingpong_buffer
    import accel_pkg::*;
#(
    parameter int dwidth = LANE_W,
    parameter int PE_Num = PE_NUM,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [PE_Num*dwidth-1:0] din,
    input  logic                     wr_commit,
    output logic                     wr_ready,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic                     rd_release,
    output logic                     rd_ready,
    output logic [PE_Num*dwidth-1:0] dout,
    output logic                     dout_vld,
    output logic [1:0]               banks_full,
    output logic                     err
);
    localparam int WORD_W = word_width(dwidth, PE_Num);

    logic [1:0] full_q, full_d;
    logic       wsel_q, wsel_d;
    logic       rsel_q, rsel_d;
    logic       err_q, err_d;
    logic       vld_q, vld_d;
    logic       rbank_q, rbank_d;
    logic       primed_q, primed_d;
    logic       wr_ok, commit_ok, rd_ok, rel_ok;
    logic [WORD_W-1:0] bank_rdata [2];

    assign wr_ready   = ~full_q[wsel_q];
    assign rd_ready   = full_q[rsel_q];
    assign banks_full = {1'b0, full_q[0]} + {1'b0, full_q[1]};
    assign err        = err_q;
    assign dout_vld   = vld_q;

    assign wr_ok     = wr_en & wr_ready;
    assign commit_ok = wr_commit & wr_ready;
    assign rd_ok     = rd_en & rd_ready;
    assign rel_ok    = rd_release & rd_ready;

    always_comb begin
        full_d   = full_q;
        wsel_d   = wsel_q ^ commit_ok;
        rsel_d   = rsel_q ^ rel_ok;
        vld_d    = rd_ok;
        rbank_d  = rd_ok ? rsel_q : rbank_q;
        primed_d = primed_q | rd_ok;
        err_d    = err_q
                 | (wr_en & ~wr_ready) | (wr_commit & ~wr_ready)
                 | (rd_en & ~rd_ready) | (rd_release & ~rd_ready);
        // Commit targets an empty bank and release a full one, so they never collide.
        if (commit_ok) begin
            full_d[wsel_q] = 1'b1;
        end
        if (rel_ok) begin
            full_d[rsel_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q   <= '0;
            wsel_q   <= 1'b0;
            rsel_q   <= 1'b0;
            err_q    <= 1'b0;
            vld_q    <= 1'b0;
            rbank_q  <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            full_q   <= full_d;
            wsel_q   <= wsel_d;
            rsel_q   <= rsel_d;
            err_q    <= err_d;
            vld_q    <= vld_d;
            rbank_q  <= rbank_d;
            primed_q <= primed_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        sdp_bram #(
            .DATA_W (WORD_W),
            .ADDR_W (ADDR_W)
        ) u_bram (
            .clk     (clk),
            .we_i    (wr_ok & (wsel_q == 1'(gi))),
            .waddr_i (wr_addr),
            .wdata_i (din),
            .re_i    (rd_ok & (rsel_q == 1'(gi))),
            .raddr_i (rd_addr),
            .rdata_o (bank_rdata[gi])
        );
    end

    // RAM output registers are not reset; hide them until the first read lands.
    assign dout = primed_q ? bank_rdata[rbank_q] : '0;
endmodule
